// File: rtl/color_map_dma.sv
// color_map_dma: streams per-pixel iteration counts from the MIG read FIFO
// through an external palette LUT and burst-writes 24-bit colours back to
// the frame buffer.
// Ports:
//   clk, reset (async, active-low), mem_calib_done (async)
//   frame control : total_pixels, max_iter, continuous, start, anim_en,
//                   busy, frame_done, dbg_state
//   read FIFO     : rd_data, rd_count, rd_empty, rd_en
//   write FIFO    : wr_count, wr_empty, wr_data, wr_en
//   palette       : lut_addr, lut_color (valid LUT_LAT edges after lut_addr)
//   MIG command   : cmd_instr, cmd_bl, cmd_byte_addr, cmd_en
module color_map_dma #(
    parameter int unsigned BURST_MAX    = 64,
    parameter logic [29:0] SRC_BASE     = 30'd0,
    parameter logic [29:0] DST_BASE     = 30'd5242880,
    parameter int unsigned LUT_AW       = 8,
    parameter int unsigned LUT_LAT      = 1,
    parameter int unsigned ANIM_DIV_W   = 24,
    parameter logic [23:0] INSIDE_COLOR = 24'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_calib_done,
    input  logic [20:0]       total_pixels,
    input  logic [31:0]       max_iter,
    input  logic              continuous,
    input  logic              start,
    input  logic              anim_en,
    output logic              busy,
    output logic              frame_done,
    output logic [3:0]        dbg_state,
    input  logic [31:0]       rd_data,
    input  logic [6:0]        rd_count,
    input  logic              rd_empty,
    output logic              rd_en,
    input  logic [6:0]        wr_count,
    input  logic              wr_empty,
    output logic [31:0]       wr_data,
    output logic              wr_en,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [23:0]       lut_color,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [29:0]       cmd_byte_addr,
    output logic              cmd_en
);

    localparam int unsigned PIX_W  = 21;
    localparam int unsigned AMT_W  = 7;
    localparam int unsigned ADDR_W = 30;

    typedef enum logic [3:0] {
        S_CAL     = 4'd0,
        S_IDLE    = 4'd1,
        S_RD_CMD  = 4'd2,
        S_RD_WAIT = 4'd3,
        S_STREAM  = 4'd4,
        S_DRAIN   = 4'd5,
        S_WR_CMD  = 4'd6,
        S_WR_WAIT = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t              state;
    logic                calib_meta, calib_sync;
    logic [PIX_W-1:0]    tp, pix_idx;
    logic [31:0]         mi;
    logic [LUT_AW-1:0]   frame_off, offset;
    logic [AMT_W-1:0]    amt, cnt;
    logic [ANIM_DIV_W-1:0] anim_cnt;
    logic [LUT_LAT-1:0]  v_sr, in_sr;

    logic [PIX_W-1:0]    remain_c, pix_next_c;
    logic [AMT_W-1:0]    amt_c;
    logic [ADDR_W-1:0]   src_addr_c, dst_addr_c;

    // Burst sizing and byte addresses (30-bit, wrapping).
    always_comb begin
        remain_c   = tp - pix_idx;
        amt_c      = (remain_c >= PIX_W'(BURST_MAX)) ? AMT_W'(BURST_MAX) : AMT_W'(remain_c);
        pix_next_c = pix_idx + PIX_W'(amt);
        src_addr_c = SRC_BASE + (ADDR_W'(pix_idx) << 2);
        dst_addr_c = DST_BASE + (ADDR_W'(pix_idx) << 2);
    end

    assign dbg_state = state;

    // Two-flop synchroniser for the asynchronous calibration flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            calib_meta <= 1'b0;
            calib_sync <= 1'b0;
        end else begin
            calib_meta <= mem_calib_done;
            calib_sync <= calib_meta;
        end
    end

    // Palette animation: offset steps once per 2**ANIM_DIV_W enabled cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anim_cnt <= '0;
            offset   <= '0;
        end else if (anim_en) begin
            anim_cnt <= anim_cnt + ANIM_DIV_W'(1);
            if (&anim_cnt) offset <= offset + LUT_AW'(1);
        end
    end

    // Pixel pipeline: the valid/inside flags travel alongside the LUT lookup
    // so the colour is captured on the LUT_LAT-th edge after lut_addr launches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lut_addr <= '0;
            v_sr     <= '0;
            in_sr    <= '0;
            wr_en    <= 1'b0;
            wr_data  <= '0;
        end else begin
            v_sr  <= (v_sr << 1) | LUT_LAT'(rd_en);
            in_sr <= (in_sr << 1) | LUT_LAT'(rd_data >= mi);
            if (rd_en) lut_addr <= rd_data[LUT_AW-1:0] + frame_off;
            wr_en <= v_sr[LUT_LAT-1];
            if (v_sr[LUT_LAT-1])
                wr_data <= {8'h00, in_sr[LUT_LAT-1] ? INSIDE_COLOR : lut_color};
        end
    end

    // Frame sequencer. cmd_en is visible in the first cycle of each *_WAIT
    // state, so the FIFO flags are ignored in that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_CAL;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            rd_en         <= 1'b0;
            cmd_en        <= 1'b0;
            cmd_instr     <= '0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
            tp            <= '0;
            mi            <= '0;
            frame_off     <= '0;
            pix_idx       <= '0;
            amt           <= '0;
            cnt           <= '0;
        end else begin
            frame_done <= 1'b0;
            cmd_en     <= 1'b0;
            case (state)
                S_CAL: if (calib_sync) state <= S_IDLE;
                S_IDLE: begin
                    if (start || continuous) begin
                        tp        <= total_pixels;
                        mi        <= max_iter;
                        frame_off <= offset;
                        pix_idx   <= '0;
                        busy      <= 1'b1;
                        state     <= (total_pixels == '0) ? S_DONE : S_RD_CMD;
                    end
                end
                S_RD_CMD: begin
                    if (rd_empty) begin
                        amt           <= amt_c;
                        cmd_en        <= 1'b1;
                        cmd_instr     <= 3'b001;
                        cmd_bl        <= 6'(amt_c - AMT_W'(1));
                        cmd_byte_addr <= src_addr_c;
                        state         <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (!cmd_en && (rd_count >= amt)) begin
                        rd_en <= 1'b1;
                        cnt   <= amt;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) begin
                        rd_en <= 1'b0;
                        cnt   <= AMT_W'(LUT_LAT);
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    cnt <= cnt - AMT_W'(1);
                    if (cnt == AMT_W'(1)) state <= S_WR_CMD;
                end
                S_WR_CMD: begin
                    cmd_en        <= 1'b1;
                    cmd_instr     <= 3'b000;
                    cmd_bl        <= 6'(amt - AMT_W'(1));
                    cmd_byte_addr <= dst_addr_c;
                    state         <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (!cmd_en && wr_empty && (wr_count == '0)) begin
                        pix_idx <= pix_next_c;
                        state   <= (pix_next_c == tp) ? S_DONE : S_RD_CMD;
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    pix_idx    <= '0;
                    state      <= S_IDLE;
                end
                default: state <= S_CAL;
            endcase
        end
    end

endmodule

// File: tb/tb_color_map_dma.sv
// tb_color_map_dma: scoreboard bench for color_map_dma with a behavioural
// MIG FIFO/command model and a two-cycle palette LUT.
module tb_color_map_dma;

    localparam logic [29:0] DST  = 30'd5242880;
    localparam logic [23:0] INS  = 24'h123456;

    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_calib_done = 1'b0;
    logic [20:0] total_pixels = '0;
    logic [31:0] max_iter = 32'd1000;
    logic        continuous = 1'b0;
    logic        start = 1'b0;
    logic        anim_en = 1'b0;
    logic        busy, frame_done;
    logic [3:0]  dbg_state;
    logic [31:0] rd_data = '0;
    logic [6:0]  rd_count = '0;
    logic        rd_empty = 1'b1;
    logic        rd_en;
    logic [6:0]  wr_count = '0;
    logic        wr_empty = 1'b1;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [7:0]  lut_addr;
    logic [7:0]  lut_q = '0;
    logic [23:0] lut_color;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;
    logic        cmd_en;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int exp_done = 0;
    cmd_t        exp_cmd[$];
    logic [31:0] exp_wr[$];
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] src_mem [0:255];

    color_map_dma #(
        .LUT_LAT(2), .ANIM_DIV_W(4), .INSIDE_COLOR(INS)
    ) dut (
        .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
        .total_pixels(total_pixels), .max_iter(max_iter), .continuous(continuous),
        .start(start), .anim_en(anim_en), .busy(busy), .frame_done(frame_done),
        .dbg_state(dbg_state), .rd_data(rd_data), .rd_count(rd_count),
        .rd_empty(rd_empty), .rd_en(rd_en), .wr_count(wr_count), .wr_empty(wr_empty),
        .wr_data(wr_data), .wr_en(wr_en), .lut_addr(lut_addr), .lut_color(lut_color),
        .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .cmd_en(cmd_en)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] color_f(input logic [7:0] a);
        return {a, ~a, 8'h3C};
    endfunction

    // Palette: address registered once, colour decoded from it.
    always @(posedge clk) lut_q <= lut_addr;
    assign lut_color = color_f(lut_q);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] addr);
        cmd_t c;
        c.instr = instr; c.bl = bl; c.addr = addr;
        exp_cmd.push_back(c);
    endtask

    // Expected colours for pixels first..tp-1 of a frame.
    task automatic push_data(input int first, input int tp, input logic [31:0] mi, input logic [7:0] off);
        for (int i = first; i < tp; i++) begin
            logic [31:0] v;
            logic [7:0]  a;
            v = src_mem[i];
            a = v[7:0] + off;
            exp_wr.push_back(v >= mi ? {8'h00, INS} : {8'h00, color_f(a)});
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_seen < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(done_seen >= target), 64'd1);
    endtask

    // MIG model: read fills arrive 3 cycles after a read command, the write
    // FIFO drains 4 cycles after a write command.
    initial begin
        int rd_delay, wr_delay, rd_idx, rd_n;
        rd_delay = 0; wr_delay = 0; rd_idx = 0; rd_n = 0;
        forever begin
            @(posedge clk);
            if (!reset) begin
                rd_q.delete(); wr_q.delete();
                rd_delay = 0; wr_delay = 0;
            end else begin
                if (rd_en && rd_q.size() > 0) void'(rd_q.pop_front());
                if (wr_en) wr_q.push_back(wr_data);
                if (cmd_en && cmd_instr == 3'b001) begin
                    rd_idx = int'(cmd_byte_addr >> 2);
                    rd_n = int'(cmd_bl) + 1;
                    rd_delay = 3;
                end
                if (cmd_en && cmd_instr == 3'b000) wr_delay = 4;
                if (rd_delay > 0) begin
                    rd_delay--;
                    if (rd_delay == 0)
                        for (int k = 0; k < rd_n; k++) rd_q.push_back(src_mem[(rd_idx + k) % 256]);
                end
                if (wr_delay > 0) begin
                    wr_delay--;
                    if (wr_delay == 0) wr_q.delete();
                end
            end
            rd_data  <= (rd_q.size() > 0) ? rd_q[0] : 32'd0;
            rd_count <= 7'(rd_q.size());
            rd_empty <= (rd_q.size() == 0);
            wr_count <= 7'(wr_q.size());
            wr_empty <= (wr_q.size() == 0);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command, a
    // write push or a frame_done pulse.
    initial begin
        cmd_t e;
        forever begin
            @(negedge clk);
            if (cmd_en) begin
                if (exp_cmd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_cmd: got %0h/%0d/%0h expected none", cmd_instr, cmd_bl, cmd_byte_addr);
                end else begin
                    e = exp_cmd.pop_front();
                    chk("cmd", 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 64'(e));
                    if (e.instr == 3'b000)
                        chk("burst_push_count", 64'(wr_q.size()), 64'(e.bl) + 64'd1);
                end
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_wr: got %0h expected none", wr_data);
                end else begin
                    chk("wr_data", 64'(wr_data), 64'(exp_wr.pop_front()));
                end
            end
            if (frame_done) begin
                chk("frame_done_expected", 64'(exp_done > 0), 64'd1);
                if (exp_done > 0) exp_done--;
                done_seen++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 256; i++) src_mem[i] = 32'(i * 5);
        src_mem[0] = 32'd5;
        src_mem[1] = 32'd1000;
        src_mem[2] = 32'd999;
        src_mem[40] = 32'd1000;
        src_mem[150] = 32'd4000;

        // Reset state and calibration gating.
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, frame_done, dbg_state, rd_en, wr_en, wr_data, lut_addr, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr}), 64'd0);
        reset = 1'b1;
        total_pixels = 21'd200;
        pulse_start();
        repeat (40) @(negedge clk);
        chk("calib_low_busy", 64'(busy), 64'd0);
        chk("calib_low_state", 64'(dbg_state), 64'd0);

        // Animation: 48 enabled cycles -> offset 3, then frozen.
        @(negedge clk); anim_en = 1'b1;
        repeat (48) @(negedge clk);
        anim_en = 1'b0;
        mem_calib_done = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_calib", 64'(dbg_state), 64'd1);

        // Frame A: tp=200, four bursts, frame_off=3.
        push_cmd(3'b001, 6'd63, 30'd0);   push_cmd(3'b000, 6'd63, DST);
        push_cmd(3'b001, 6'd63, 30'd256); push_cmd(3'b000, 6'd63, DST + 30'd256);
        push_cmd(3'b001, 6'd63, 30'd512); push_cmd(3'b000, 6'd63, DST + 30'd512);
        push_cmd(3'b001, 6'd7,  30'd768); push_cmd(3'b000, 6'd7,  DST + 30'd768);
        exp_wr.push_back(32'h0008F73C);
        exp_wr.push_back(32'h00123456);
        exp_wr.push_back(32'h00EA153C);
        push_data(3, 200, 32'd1000, 8'd3);
        exp_done++;
        pulse_start();
        chk("busy_after_start", 64'(busy), 64'd1);
        n = 0;
        while (lut_addr == 8'd0 && n < 100) begin @(negedge clk); n++; end
        chk("lut_addr_first", 64'(lut_addr), 64'd8);
        repeat (2) @(negedge clk);
        chk("lut_to_wr_en", 64'(wr_en), 64'd1);
        chk("lut_to_wr_data", 64'(wr_data), 64'h0008F73C);
        pulse_start();
        wait_done(1, 2000, "frame_a_done");
        chk("busy_after_done", 64'(busy), 64'd0);
        repeat (150) @(negedge clk);

        // Zero-size frame: done without any command.
        total_pixels = 21'd0;
        exp_done++;
        pulse_start();
        wait_done(2, 6, "tp0_done");
        repeat (10) @(negedge clk);

        // Continuous mode: three 64-pixel frames, mid-frame starts ignored.
        total_pixels = 21'd64;
        for (int f = 0; f < 3; f++) begin
            push_cmd(3'b001, 6'd63, 30'd0);
            push_cmd(3'b000, 6'd63, DST);
            push_data(0, 64, 32'd1000, 8'd3);
        end
        exp_done += 3;
        @(negedge clk); continuous = 1'b1;
        repeat (30) @(negedge clk);
        pulse_start();
        wait_done(4, 1000, "cont_frame2_done");
        repeat (2) @(negedge clk);
        pulse_start();
        continuous = 1'b0;
        wait_done(5, 1000, "cont_frame3_done");
        repeat (150) @(negedge clk);

        // Reset while streaming abandons the frame; offset returns to 0.
        total_pixels = 21'd200;
        push_cmd(3'b001, 6'd63, 30'd0);
        pulse_start();
        n = 0;
        while (!rd_en && n < 100) begin @(negedge clk); n++; end
        chk("stream_reached", 64'(rd_en), 64'd1);
        reset = 1'b0;
        mem_calib_done = 1'b0;
        #1;
        chk("reset_mid_stream", 64'({busy, frame_done, dbg_state, rd_en, wr_en, wr_data, lut_addr, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr}), 64'd0);
        chk("abandoned_cmds", 64'(exp_cmd.size()), 64'd0);
        exp_wr.delete();
        exp_cmd.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("cal_after_reset", 64'(dbg_state), 64'd0);
        mem_calib_done = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_after_recal", 64'(dbg_state), 64'd1);
        total_pixels = 21'd64;
        push_cmd(3'b001, 6'd63, 30'd0);
        push_cmd(3'b000, 6'd63, DST);
        push_data(0, 64, 32'd1000, 8'd0);
        exp_done++;
        pulse_start();
        wait_done(6, 1000, "post_reset_done");
        repeat (20) @(negedge clk);

        chk("cmd_left", 64'(exp_cmd.size()), 64'd0);
        chk("wr_left", 64'(exp_wr.size()), 64'd0);
        chk("done_left", 64'(exp_done), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
